// File: rtl/regfile_write_scheduler_if.sv
// WB and LU write handshakes into the register-file write scheduler.
interface regfile_write_scheduler_if;
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        wb_hold;
    logic        lu_valid;
    logic [4:0]  lu_a;
    logic [31:0] lu_d;
    logic        lu_ready;

    modport master (
        output wb_we, wb_a, wb_d, lu_valid, lu_a, lu_d,
        input  wb_hold, lu_ready
    );

    modport slave (
        input  wb_we, wb_a, wb_d, lu_valid, lu_a, lu_d,
        output wb_hold, lu_ready
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: zero-fills all 32 entries after reset, then
// arbitrates WB against the long-latency unit and tracks LU-pending registers.
module regfile_write_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] INIT_VALUE   = 32'h0
) (
    input  logic                      clock,
    input  logic                      reset,
    regfile_write_scheduler_if.slave  bus,
    output logic                      init_done,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_a,
    input  logic [4:0]                chk_a1,
    input  logic [4:0]                chk_a2,
    output logic                      hazard,
    output logic [31:0]               busy,
    output logic                      rf_we,
    output logic [4:0]                rf_a3,
    output logic [31:0]               rf_wd
);
    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  idx_r;
    logic [31:0] busy_r;
    logic [31:0] busy_nxt_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [3:0]  starve_r;
    logic [3:0]  starve_nxt_s;
    logic        force_s;
    logic        wb_grant_s;
    logic        lu_ready_s;
    logic        lu_xfer_s;
    logic        wb_hold_s;
    logic        rf_we_s;
    logic [4:0]  rf_a3_s;
    logic [31:0] rf_wd_s;
    logic        hazard_s;
    logic        init_done_s;

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next state: INIT sweeps every entry once, RUN holds until reset
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (idx_r == 5'd31) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // outputs: arbitration, write port and hazard decode
    always_comb begin
        force_s     = 1'b0;
        wb_grant_s  = 1'b0;
        lu_ready_s  = 1'b0;
        lu_xfer_s   = 1'b0;
        wb_hold_s   = 1'b1;
        rf_we_s     = 1'b0;
        rf_a3_s     = 5'd0;
        rf_wd_s     = 32'd0;
        hazard_s    = 1'b1;
        init_done_s = 1'b0;
        if (!reset) begin
            case (state_r)
                ST_INIT: begin
                    rf_we_s = 1'b1;
                    rf_a3_s = idx_r;
                    rf_wd_s = INIT_VALUE;
                end
                ST_RUN: begin
                    init_done_s = 1'b1;
                    force_s     = (starve_r == LIMIT) && bus.lu_valid;
                    if (force_s) begin
                        lu_ready_s = 1'b1;
                        wb_hold_s  = bus.wb_we;
                    end else if (bus.wb_we) begin
                        wb_grant_s = 1'b1;
                        wb_hold_s  = 1'b0;
                    end else begin
                        lu_ready_s = 1'b1;
                        wb_hold_s  = 1'b0;
                    end
                    lu_xfer_s = bus.lu_valid && lu_ready_s;
                    // r0 handshakes complete but never reach the array
                    if (wb_grant_s) begin
                        rf_we_s = (bus.wb_a != 5'd0);
                        rf_a3_s = bus.wb_a;
                        rf_wd_s = bus.wb_d;
                    end else if (lu_xfer_s) begin
                        rf_we_s = (bus.lu_a != 5'd0);
                        rf_a3_s = bus.lu_a;
                        rf_wd_s = bus.lu_d;
                    end else begin
                        rf_we_s = 1'b0;
                    end
                    hazard_s = (busy_r[chk_a1] && (chk_a1 != 5'd0))
                             || (busy_r[chk_a2] && (chk_a2 != 5'd0))
                             || (issue_valid && busy_r[issue_a]);
                end
                default: hazard_s = 1'b1;
            endcase
        end else begin
            hazard_s = 1'b1;
        end
    end

    assign set_mask_s   = (!reset && (state_r == ST_RUN) && issue_valid && (issue_a != 5'd0))
                        ? (32'd1 << issue_a) : 32'd0;
    assign clr_mask_s   = lu_xfer_s ? (32'd1 << bus.lu_a) : 32'd0;
    assign busy_nxt_s   = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    assign starve_nxt_s = (bus.lu_valid && !lu_ready_s)
                        ? ((starve_r == LIMIT) ? starve_r : (starve_r + 4'd1))
                        : 4'd0;

    // INIT sweep index
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_r <= 5'd0;
        end else if (state_r == ST_INIT) begin
            idx_r <= idx_r + 5'd1;
        end
    end

    // LU-pending scoreboard and starvation counter
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r   <= 32'd0;
            starve_r <= 4'd0;
        end else begin
            busy_r   <= busy_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end

    assign bus.wb_hold  = wb_hold_s;
    assign bus.lu_ready = lu_ready_s;
    assign init_done    = init_done_s;
    assign hazard       = hazard_s;
    assign busy         = busy_r;
    assign rf_we        = rf_we_s;
    assign rf_a3        = rf_a3_s;
    assign rf_wd        = rf_wd_s;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed and randomized bench for regfile_write_scheduler with a reference model.
`timescale 1ns/1ps
module tb_regfile_write_scheduler;
    localparam int          LIMIT = 4;
    localparam logic [31:0] IV    = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_a, chk_a1, chk_a2;
    logic        init_done, hazard, rf_we;
    logic [31:0] busy, rf_wd;
    logic [4:0]  rf_a3;

    int checks = 0;
    int failures = 0;

    regfile_write_scheduler_if bus();

    regfile_write_scheduler #(.STARVE_LIMIT(LIMIT), .INIT_VALUE(IV)) dut (
        .clock(clock), .reset(reset), .bus(bus), .init_done(init_done),
        .issue_valid(issue_valid), .issue_a(issue_a), .chk_a1(chk_a1), .chk_a2(chk_a2),
        .hazard(hazard), .busy(busy), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
    );

    always #5 clock = ~clock;

    // reference model state
    bit          m_run;
    int          m_cnt;
    bit [31:0]   m_busy;
    int          m_starve;
    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32];
    // expected outputs and next model state
    logic        e_we, e_ready, e_hold, e_done, e_haz;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    bit          n_run;
    int          n_cnt, n_starve;
    bit [31:0]   n_busy;
    // DUT outputs sampled before the edge
    logic        s_rf_we, s_lu_ready, s_wb_hold, s_init_done, s_hazard, s_lu_valid, s_wb_we;
    logic [4:0]  s_rf_a3;
    logic [31:0] s_rf_wd, s_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit frc, wbg, lug;
        #3;
        if (reset) begin
            e_we = 1'b0; e_ready = 1'b0; e_hold = 1'b1; e_done = 1'b0; e_haz = 1'b1;
            e_a3 = 5'd0; e_wd = 32'd0;
            n_run = 1'b0; n_cnt = 0; n_busy = '0; n_starve = 0;
        end else begin
            if (!m_run) begin
                e_we = 1'b1; e_a3 = m_cnt[4:0]; e_wd = IV;
                e_ready = 1'b0; e_hold = 1'b1; e_done = 1'b0; e_haz = 1'b1;
                n_cnt = m_cnt + 1; n_run = (n_cnt == 32); n_busy = m_busy;
            end else begin
                frc = (m_starve == LIMIT) && bus.lu_valid;
                wbg = !frc && bus.wb_we;
                e_ready = frc || !bus.wb_we;
                e_hold  = frc && bus.wb_we;
                lug = bus.lu_valid && e_ready;
                e_done = 1'b1;
                if (wbg) begin
                    e_we = (bus.wb_a != 0); e_a3 = bus.wb_a; e_wd = bus.wb_d;
                end else if (lug) begin
                    e_we = (bus.lu_a != 0); e_a3 = bus.lu_a; e_wd = bus.lu_d;
                end else begin
                    e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0;
                end
                e_haz = (chk_a1 != 0 && m_busy[chk_a1]) || (chk_a2 != 0 && m_busy[chk_a2])
                      || (issue_valid && m_busy[issue_a]);
                n_run = 1'b1; n_cnt = m_cnt; n_busy = m_busy;
                if (lug) n_busy[bus.lu_a] = 1'b0;
                if (issue_valid && issue_a != 0) n_busy[issue_a] = 1'b1;
            end
            if (bus.lu_valid && !e_ready) n_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else n_starve = 0;
        end
        chk("rf_we", rf_we, e_we);
        chk("lu_ready", bus.lu_ready, e_ready);
        chk("wb_hold", bus.wb_hold, e_hold);
        chk("init_done", init_done, e_done);
        chk("hazard", hazard, e_haz);
        chk("busy", busy, m_busy);
        if (!reset) begin
            chk("rf_a3", rf_a3, e_a3);
            chk("rf_wd", rf_wd, e_wd);
        end
        s_rf_we = rf_we; s_rf_a3 = rf_a3; s_rf_wd = rf_wd; s_lu_ready = bus.lu_ready;
        s_wb_hold = bus.wb_hold; s_init_done = init_done; s_hazard = hazard; s_busy = busy;
        s_lu_valid = bus.lu_valid; s_wb_we = bus.wb_we;
        @(posedge clock);
        #1;
        if (s_rf_we === 1'b1) d_rf[s_rf_a3] = s_rf_wd;
        if (e_we) m_rf[e_a3] = e_wd;
        m_run = n_run; m_cnt = n_cnt; m_busy = n_busy; m_starve = n_starve;
    endtask

    task automatic idle_inputs();
        bus.wb_we = 1'b0; bus.wb_a = 5'd0; bus.wb_d = 32'd0;
        bus.lu_valid = 1'b0; bus.lu_a = 5'd0; bus.lu_d = 32'd0;
        issue_valid = 1'b0; issue_a = 5'd0; chk_a1 = 5'd0; chk_a2 = 5'd0;
    endtask

    // counts INIT cycles (init_done low) after reset release, bounded
    task automatic count_init(input string tag);
        int zeros;
        zeros = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (s_init_done === 1'b1) break;
            zeros++;
        end
        chk(tag, zeros, 32);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        m_run = 1'b0; m_cnt = 0; m_busy = '0; m_starve = 0;

        // reset state
        step();
        reset = 1'b0;

        // 1: INIT sweep writes INIT_VALUE to r0..r31
        for (int i = 0; i < 32; i++) begin
            step();
            chk("init_we", s_rf_we, 1);
            chk("init_a3", s_rf_a3, i);
            chk("init_wd", s_rf_wd, IV);
        end
        step();
        chk("init_done_rise", s_init_done, 1);
        for (int i = 0; i < 32; i++) chk("rf_zero", d_rf[i], 32'd0);

        // 2: WB beats LU; LU accepted once WB drops
        bus.wb_we = 1'b1; bus.wb_a = 5'd5; bus.wb_d = 32'hDEADBEEF;
        bus.lu_valid = 1'b1; bus.lu_a = 5'd7; bus.lu_d = 32'h0000_7777;
        step();
        chk("t2_a3", s_rf_a3, 5);
        chk("t2_lu_ready", s_lu_ready, 0);
        bus.wb_we = 1'b0;
        step();
        chk("t2_lu_take", s_lu_ready, 1);
        chk("t2_lu_a3", s_rf_a3, 7);
        chk("t2_r7", d_rf[7], 32'h0000_7777);
        bus.lu_valid = 1'b0;

        // 3: starvation relief after LIMIT blocked cycles
        bus.wb_we = 1'b1; bus.wb_a = 5'd3; bus.wb_d = 32'h3333_0000;
        bus.lu_valid = 1'b1; bus.lu_a = 5'd8; bus.lu_d = 32'h8888_0000;
        for (int i = 0; i < LIMIT; i++) begin
            step();
            chk("t3_wb_a3", s_rf_a3, 3);
        end
        step();
        chk("t3_force_a3", s_rf_a3, 8);
        chk("t3_force_hold", s_wb_hold, 1);
        chk("t3_force_ready", s_lu_ready, 1);
        bus.lu_valid = 1'b0;
        step();
        chk("t3_resume_a3", s_rf_a3, 3);
        chk("t3_resume_hold", s_wb_hold, 0);
        bus.wb_we = 1'b0;

        // 4: RAW and WAW hazards on an LU-pending register
        issue_valid = 1'b1; issue_a = 5'd9;
        step();
        chk("t4_no_haz", s_hazard, 0);
        issue_valid = 1'b0; chk_a1 = 5'd9;
        step();
        chk("t4_raw", s_hazard, 1);
        issue_valid = 1'b1; chk_a1 = 5'd0;
        step();
        chk("t4_waw", s_hazard, 1);
        issue_valid = 1'b0; chk_a1 = 5'd9;
        bus.lu_valid = 1'b1; bus.lu_a = 5'd9; bus.lu_d = 32'h9999_9999;
        step();
        chk("t4_haz_xfer", s_hazard, 1);
        chk("t4_xfer", s_lu_ready, 1);
        bus.lu_valid = 1'b0;
        step();
        chk("t4_haz_clr", s_hazard, 0);
        chk("t4_busy9", s_busy[9], 0);
        chk_a1 = 5'd0;

        // 5: r0 destinations complete handshakes without writing
        bus.wb_we = 1'b1; bus.wb_a = 5'd0; bus.wb_d = 32'h1234_5678;
        step();
        chk("t5_wb0_we", s_rf_we, 0);
        chk("t5_wb0_hold", s_wb_hold, 0);
        bus.wb_we = 1'b0;
        bus.lu_valid = 1'b1; bus.lu_a = 5'd0; bus.lu_d = 32'hABCD_0000;
        issue_valid = 1'b1; issue_a = 5'd4;
        step();
        chk("t5_lu0_ready", s_lu_ready, 1);
        chk("t5_lu0_we", s_rf_we, 0);
        bus.lu_valid = 1'b0; issue_a = 5'd0;
        step();
        issue_valid = 1'b0;
        step();
        chk("t5_issue0", s_busy, 32'h0000_0010);

        // randomized traffic respecting the hold/valid rules
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (!(s_wb_we && s_wb_hold)) begin
                bus.wb_we = ($urandom_range(0, 1) == 1);
                bus.wb_a  = 5'($urandom_range(0, 31));
                bus.wb_d  = $urandom;
            end
            if (!(s_lu_valid && !s_lu_ready)) begin
                bus.lu_valid = ($urandom_range(0, 2) == 0);
                bus.lu_a     = 5'($urandom_range(0, 31));
                bus.lu_d     = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_a     = 5'($urandom_range(0, 31));
            chk_a1      = 5'($urandom_range(0, 31));
            chk_a2      = 5'($urandom_range(0, 31));
            step();
        end
        reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 40; k++) begin
            if (s_init_done === 1'b1) break;
            step();
        end
        chk("rand_settle", s_init_done, 1);
        for (int i = 0; i < 32; i++) chk("rf_match", d_rf[i], m_rf[i]);

        // 6: reset in RUN with BUSY set, then mid-INIT at IDX=12
        issue_valid = 1'b1; issue_a = 5'd6;
        step();
        issue_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("t6_busy_before", s_busy[6], 1);
        reset = 1'b0;
        step();
        chk("t6_busy_clr", s_busy, 0);
        chk("t6_restart_a3", s_rf_a3, 0);
        for (int i = 1; i < 12; i++) step();
        chk("t6_mid_a3", s_rf_a3, 11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_init("t6_init_len");
        for (int i = 0; i < 32; i++) chk("rf_final", d_rf[i], m_rf[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
